// File: rtl/fft_requant_pkg.sv
// Shared widths and helpers for the butterfly requantiser.
// Used by requant_lane and butterfly_requant.
package fft_requant_pkg;

  localparam int DEF_IN_WIDTH    = 45;
  localparam int DEF_OUT_WIDTH   = 27;
  localparam int DEF_SHIFT       = 15;
  localparam int DEF_FRAME_PAIRS = 512;
  localparam int DEF_SAT_CNT_W   =
    $clog2(4 * DEF_FRAME_PAIRS) + 1;

  typedef struct packed {
    logic valid;
    logic last;
    logic len_err;
  } beat_tag_t;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic logic [2:0] popcount4(
    input logic [3:0] v
  );
    return 3'(v[0]) + 3'(v[1]) +
           3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One component: round, shift, then saturate, two register stages.
// BUTTERFLY_REQUANT_CONVERGENT_EN selects round-half-to-even.
module requant_lane
  import fft_requant_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int SHIFT     = DEF_SHIFT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s0_valid,
  input  logic                        s1_valid,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  localparam int RW = IN_WIDTH + 1 - SHIFT;

  localparam logic [IN_WIDTH:0] HALF =
    (IN_WIDTH+1)'(1) << (SHIFT - 1);

  localparam logic signed [RW-1:0] HI =
    RW'(sat_max(OUT_WIDTH));
  localparam logic signed [RW-1:0] LO =
    RW'(sat_min(OUT_WIDTH));

  localparam logic signed [OUT_WIDTH-1:0] HI_O =
    OUT_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [OUT_WIDTH-1:0] LO_O =
    OUT_WIDTH'(sat_min(OUT_WIDTH));

  logic [IN_WIDTH:0]              ext;
  logic [IN_WIDTH:0]              biased;
  logic [SHIFT-1:0]               frac;
  logic signed [RW-1:0]           rnd;
  logic signed [RW-1:0]           rnd_c;
  logic signed [RW-1:0]           rnd_q;
  logic signed [OUT_WIDTH-1:0]    sat_val;
  logic                           over;
  logic                           under;

  // One sign bit of headroom keeps the bias add from overflowing.
  assign ext    = {din[IN_WIDTH-1], din};
  assign biased = ext + HALF;
  assign rnd    = $signed(biased[IN_WIDTH:SHIFT]);
  assign frac   = biased[SHIFT-1:0];

`ifdef BUTTERFLY_REQUANT_CONVERGENT_EN
  // Zero residue after the bias means an exact tie.
  always_comb begin
    rnd_c = rnd;
    if (frac == '0) begin
      rnd_c = {rnd[RW-1:1], 1'b0};
    end
  end
`else
  logic unused_frac;
  assign unused_frac = |frac;
  assign rnd_c       = rnd;
`endif

  always_comb begin
    over  = rnd_q > HI;
    under = rnd_q < LO;
    unique case (1'b1)
      over:    sat_val = HI_O;
      under:   sat_val = LO_O;
      default: sat_val = rnd_q[OUT_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
    end else if (s0_valid) begin
      rnd_q <= rnd_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (s1_valid) begin
      dout <= sat_val;
      sat  <= over | under;
    end
  end

endmodule

// File: rtl/butterfly_requant.sv
// Requantises four butterfly outputs and tracks frame statistics.
// BUTTERFLY_REQUANT_CONVERGENT_EN selects round-half-to-even.
module butterfly_requant
  import fft_requant_pkg::*;
#(
  parameter int IN_WIDTH    = DEF_IN_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int SHIFT       = DEF_SHIFT,
  parameter int FRAME_PAIRS = DEF_FRAME_PAIRS,
  parameter int SAT_CNT_W   =
    $clog2(4 * FRAME_PAIRS) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic signed [IN_WIDTH-1:0]  in_yp_r,
  input  logic signed [IN_WIDTH-1:0]  in_yp_i,
  input  logic signed [IN_WIDTH-1:0]  in_yq_r,
  input  logic signed [IN_WIDTH-1:0]  in_yq_i,
  output logic                        out_valid,
  output logic                        out_last,
  output logic signed [OUT_WIDTH-1:0] out_yp_r,
  output logic signed [OUT_WIDTH-1:0] out_yp_i,
  output logic signed [OUT_WIDTH-1:0] out_yq_r,
  output logic signed [OUT_WIDTH-1:0] out_yq_i,
  output logic [3:0]                  out_sat,
  output logic                        frame_done,
  output logic [SAT_CNT_W-1:0]        frame_sat_cnt,
  output logic                        frame_len_err
);

  localparam int CNT_W = $clog2(FRAME_PAIRS);
  localparam logic [CNT_W-1:0] LAST_IDX =
    CNT_W'(FRAME_PAIRS - 1);

  beat_tag_t            tag0;
  beat_tag_t            tag1;
  beat_tag_t            tag2;
  logic [CNT_W-1:0]     pair_cnt;
  logic                 sticky;
  logic                 len_err;
  logic [SAT_CNT_W-1:0] sat_acc;
  logic [SAT_CNT_W:0]   sat_sum;
  logic [SAT_CNT_W-1:0] sat_next;
  logic [3:0]           lane_sat;

  requant_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_yp_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .s0_valid(in_valid),
    .s1_valid(tag1.valid),
    .din     (in_yp_r),
    .dout    (out_yp_r),
    .sat     (lane_sat[0])
  );

  requant_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_yp_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .s0_valid(in_valid),
    .s1_valid(tag1.valid),
    .din     (in_yp_i),
    .dout    (out_yp_i),
    .sat     (lane_sat[1])
  );

  requant_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_yq_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .s0_valid(in_valid),
    .s1_valid(tag1.valid),
    .din     (in_yq_r),
    .dout    (out_yq_r),
    .sat     (lane_sat[2])
  );

  requant_lane #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_yq_i (
    .clk     (clk),
    .rst_n   (rst_n),
    .s0_valid(in_valid),
    .s1_valid(tag1.valid),
    .din     (in_yq_i),
    .dout    (out_yq_i),
    .sat     (lane_sat[3])
  );

  assign out_sat    = lane_sat;
  assign out_valid  = tag2.valid;
  assign out_last   = tag2.last;
  assign frame_done = tag2.valid & tag2.last;

  assign len_err = sticky | (pair_cnt != LAST_IDX);

  always_comb begin
    tag0.valid   = in_valid;
    tag0.last    = in_valid & in_last;
    tag0.len_err = in_valid & in_last & len_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1 <= '0;
      tag2 <= '0;
    end else begin
      tag1 <= tag0;
      tag2 <= tag1;
    end
  end

  // Overlong frames pin the counter and remember it in sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      sticky   <= 1'b0;
    end else if (in_valid) begin
      if (in_last) begin
        pair_cnt <= '0;
        sticky   <= 1'b0;
      end else if (pair_cnt == LAST_IDX) begin
        sticky   <= 1'b1;
      end else begin
        pair_cnt <= pair_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sat_sum  = {1'b0, sat_acc} +
               (SAT_CNT_W+1)'(popcount4(out_sat));
    sat_next = sat_sum[SAT_CNT_W] ?
               '1 : sat_sum[SAT_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_acc       <= '0;
      frame_sat_cnt <= '0;
      frame_len_err <= 1'b0;
    end else if (out_valid) begin
      if (out_last) begin
        sat_acc       <= '0;
        frame_sat_cnt <= sat_next;
        frame_len_err <= tag2.len_err;
      end else begin
        sat_acc       <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_butterfly_requant.sv
// Directed bench for butterfly_requant with a per-cycle output model.
// Expectations follow BUTTERFLY_REQUANT_CONVERGENT_EN when defined.
module tb_butterfly_requant;

  localparam int IW = 45;
  localparam int OW = 27;
  localparam int SH = 15;
  localparam int FP = 512;
  localparam int SW = $clog2(4 * FP) + 1;

  localparam longint SC   = longint'(1) <<< SH;
  localparam longint HF   = longint'(1) <<< (SH - 1);
  localparam longint OMAX = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (OW - 1));
  localparam longint BIG  = longint'(1) <<< 41;
  localparam longint NEG  = -(longint'(1) <<< 42);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  longint xin [4];
  logic signed [IW-1:0] in_yp_r, in_yp_i;
  logic signed [IW-1:0] in_yq_r, in_yq_i;
  logic out_valid, out_last;
  logic signed [OW-1:0] out_yp_r, out_yp_i;
  logic signed [OW-1:0] out_yq_r, out_yq_i;
  logic [3:0] out_sat;
  logic frame_done;
  logic [SW-1:0] frame_sat_cnt;
  logic frame_len_err;

  int total = 0;
  int bad = 0;

  assign in_yp_r = IW'(xin[0]);
  assign in_yp_i = IW'(xin[1]);
  assign in_yq_r = IW'(xin[2]);
  assign in_yq_i = IW'(xin[3]);

  always #5 clk = ~clk;

  butterfly_requant dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_yp_r      (in_yp_r),
    .in_yp_i      (in_yp_i),
    .in_yq_r      (in_yq_r),
    .in_yq_i      (in_yq_i),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_yp_r     (out_yp_r),
    .out_yp_i     (out_yp_i),
    .out_yq_r     (out_yq_r),
    .out_yq_i     (out_yq_i),
    .out_sat      (out_sat),
    .frame_done   (frame_done),
    .frame_sat_cnt(frame_sat_cnt),
    .frame_len_err(frame_len_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic longint rnd(input longint x);
    longint fl, fr, q;
    fl = x / SC;
    if (x < 0 && fl * SC != x) fl = fl - 1;
    fr = x - fl * SC;
    q = fl + ((fr >= HF) ? 1 : 0);
`ifdef BUTTERFLY_REQUANT_CONVERGENT_EN
    if (fr == HF && q[0]) q = q - 1;
`endif
    return q;
  endfunction

  function automatic longint clampv(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  // Reference pipeline: 2-cycle latency, outputs hold between beats.
  logic m1v, m1l, ev, el;
  longint m1d [4];
  longint ed [4];
  logic [3:0] m1s, es;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1v <= 0; m1l <= 0; ev <= 0; el <= 0;
      m1s <= 0; es <= 0;
      for (int k = 0; k < 4; k++) begin
        m1d[k] <= 0; ed[k] <= 0;
      end
    end else begin
      m1v <= in_valid;
      m1l <= in_valid & in_last;
      if (in_valid) begin
        for (int k = 0; k < 4; k++) begin
          m1d[k] <= clampv(rnd(xin[k]));
          m1s[k] <= clampv(rnd(xin[k])) != rnd(xin[k]);
        end
      end
      ev <= m1v;
      el <= m1l;
      if (m1v) begin
        for (int k = 0; k < 4; k++) ed[k] <= m1d[k];
        es <= m1s;
      end
    end
  end

  int vbeats;
  logic done_d;
  int q_sat [$];
  int q_err [$];
  int q_beats [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      vbeats <= 0;
      done_d <= 0;
    end else begin
      chk("mon_valid", 64'(out_valid), 64'(ev));
      chk("mon_last", 64'(out_last), 64'(el));
      chk("mon_done", 64'(frame_done), 64'(ev & el));
      chk("mon_yp_r", 64'(out_yp_r), ed[0]);
      chk("mon_yp_i", 64'(out_yp_i), ed[1]);
      chk("mon_yq_r", 64'(out_yq_r), ed[2]);
      chk("mon_yq_i", 64'(out_yq_i), ed[3]);
      chk("mon_sat", 64'(out_sat), 64'(es));
      done_d <= frame_done;
      if (done_d) begin
        q_sat.push_back(int'(frame_sat_cnt));
        q_err.push_back(int'(frame_len_err));
      end
      if (frame_done) begin
        q_beats.push_back(vbeats + 1);
        vbeats <= 0;
      end else if (out_valid) begin
        vbeats <= vbeats + 1;
      end
    end
  end

  function automatic longint small_val();
    return longint'(int'($urandom)) <<< 8;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
      in_last = 0;
    end
  endtask

  task automatic one(input string tag, input longint a,
                     input longint b, input longint c,
                     input longint d, input longint ea,
                     input longint eb, input longint ec,
                     input longint ed_, input logic [3:0] es_);
    @(negedge clk);
    in_valid = 1; in_last = 0;
    xin[0] = a; xin[1] = b; xin[2] = c; xin[3] = d;
    @(negedge clk);
    in_valid = 0;
    chk({tag, "_v1"}, 64'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_v2"}, 64'(out_valid), 1);
    chk({tag, "_a"}, 64'(out_yp_r), ea);
    chk({tag, "_b"}, 64'(out_yp_i), eb);
    chk({tag, "_c"}, 64'(out_yq_r), ec);
    chk({tag, "_d"}, 64'(out_yq_i), ed_);
    chk({tag, "_s"}, 64'(out_sat), 64'(es_));
  endtask

  // Saturating components c fill beat c/4, lane c%4.
  task automatic frame(input int n, input int last_at,
                       input int nsat, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int j = 1; j < g; j++) begin
          @(negedge clk);
          in_valid = 0;
          in_last = 1'($urandom_range(0, 1));
          xin[0] = small_val();
        end
      end
      @(negedge clk);
      in_valid = 1;
      in_last = (i == last_at);
      for (int k = 0; k < 4; k++) begin
        if (i * 4 + k < nsat)
          xin[k] = (k % 2 == 0) ? BIG : NEG;
        else
          xin[k] = small_val();
      end
    end
  endtask

  task automatic exp_frame(input string tag, input int s,
                           input int e, input int b);
    for (int i = 0; i < 100 && q_sat.size() == 0; i++)
      @(negedge clk);
    if (q_sat.size() == 0 || q_beats.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
    end else begin
      chk({tag, "_satcnt"}, 64'(q_sat.pop_front()), 64'(s));
      chk({tag, "_lenerr"}, 64'(q_err.pop_front()), 64'(e));
      chk({tag, "_beats"}, 64'(q_beats.pop_front()), 64'(b));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_v"}, 64'(out_valid), 0);
    chk({tag, "_l"}, 64'(out_last), 0);
    chk({tag, "_a"}, 64'(out_yp_r), 0);
    chk({tag, "_d"}, 64'(out_yq_i), 0);
    chk({tag, "_s"}, 64'(out_sat), 0);
    chk({tag, "_fd"}, 64'(frame_done), 0);
    chk({tag, "_fs"}, 64'(frame_sat_cnt), 0);
    chk({tag, "_fe"}, 64'(frame_len_err), 0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) xin[k] = 0;
    repeat (3) @(negedge clk);
    #1 chk_zero("rst");
    @(negedge clk);
    #2 rst_n = 1;

    one("r15", 3 * HF, 0, 0, 0, 2, 0, 0, 0, 4'b0000);
`ifdef BUTTERFLY_REQUANT_CONVERGENT_EN
    one("rm15", -3 * HF, 0, 0, 0, -2, 0, 0, 0, 4'b0000);
    one("r25", 5 * HF, 0, 0, 0, 2, 0, 0, 0, 4'b0000);
`else
    one("rm15", -3 * HF, 0, 0, 0, -1, 0, 0, 0, 4'b0000);
    one("r25", 5 * HF, 0, 0, 0, 3, 0, 0, 0, 4'b0000);
`endif
    one("satp", 0, 0, BIG, 0, 0, 0, 67108863, 0, 4'b0100);
    one("satn", 0, 0, 0, NEG, 0, 0, 0, -67108864, 4'b1000);
    one("edge", 0, 0, BIG - SC, 0, 0, 0, 67108863, 0,
        4'b0000);

    idle(2);
    rst_n = 0;
    #1 chk_zero("rst2");
    @(negedge clk);
    #2 rst_n = 1;

    frame(FP, FP - 1, 3, 0);
    idle(3);
    exp_frame("nominal", 3, 0, FP);

    frame(101, 100, 0, 0);
    idle(2);
    exp_frame("short", 0, 1, 101);
    frame(FP, FP - 1, 1, 0);
    idle(2);
    exp_frame("after_short", 1, 0, FP);

    frame(601, 600, 0, 0);
    idle(2);
    exp_frame("long", 0, 1, 601);
    frame(FP, FP - 1, 2, 1);
    idle(2);
    exp_frame("gaps", 2, 0, FP);

    frame(FP, FP - 1, 2, 0);
    frame(FP, FP - 1, 5, 0);
    idle(3);
    exp_frame("b2b_0", 2, 0, FP);
    exp_frame("b2b_1", 5, 0, FP);

    frame(200, -1, 1, 0);
    #2 in_valid = 0;
    rst_n = 0;
    #1 chk_zero("rst_mid");
    @(negedge clk);
    #2 rst_n = 1;
    frame(FP, FP - 1, 4, 1);
    idle(3);
    exp_frame("post_rst", 4, 0, FP);
    chk("q_empty", 64'(q_sat.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_requant.md
Name: butterfly_requant

Overview:
- Downstream stage of the radix-2 butterfly in the recover-2N-point FFT path.
- Takes the four full-precision butterfly outputs (yp_r, yp_i, yq_r, yq_i), rounds, shifts right by the twiddle fraction width and saturates them back to data width for the next stage or memory write-back.
- Tracks frame framing: counts beats per frame, saturation events and frame length errors, and reports them on a per-frame done pulse.

Parameters:
- IN_WIDTH, 45, input component width (butterfly DATA_WIDTH + TWID_WIDTH + 2).
- OUT_WIDTH, 27, output component width (next-stage DATA_WIDTH).
- SHIFT, 15, right-shift amount (twiddle fraction bits); must be ≥1.
- FRAME_PAIRS, 512, butterfly pairs per frame; must be ≥2.
- SAT_CNT_W, $clog2(4*FRAME_PAIRS)+1, width of the per-frame saturation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  the four input components are valid this cycle
- in_last  in  1  last pair of frame; qualified by in_valid
- in_yp_r / in_yp_i / in_yq_r / in_yq_i  in  IN_WIDTH each  signed butterfly outputs
- out_valid  out  1  outputs valid
- out_last  out  1  last pair of frame, aligned with out_valid
- out_yp_r / out_yp_i / out_yq_r / out_yq_i  out  OUT_WIDTH each  signed requantised outputs
- out_sat  out  4  per-component saturation flag, bit order {yq_i, yq_r, yp_i, yp_r}, aligned with out_valid
- frame_done  out  1  one-cycle pulse, coincident with out_valid && out_last
- frame_sat_cnt  out  SAT_CNT_W  saturated components in the finished frame; holds until the next frame_done
- frame_len_err  out  1  finished frame length ≠ FRAME_PAIRS; holds until the next frame_done

Behaviour:
- Reset: every output is 0; internal pair counter, sat accumulator and overflow sticky bit are 0.
- Reset mid-frame discards pipeline contents; the next frame starts counting from 0.
- No backpressure; one beat per cycle is accepted when in_valid=1. Latency is exactly 2 cycles from in_valid to out_valid.
- Stage 1 (round + shift), per component:
  - Sign-extend to IN_WIDTH+1.
  - Add 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT, giving an IN_WIDTH+1-SHIFT bit result.
  - The add can never overflow.
- Stage 2 (saturate), per component:
  - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Set the corresponding out_sat bit when clamping occurred.
- Data registers capture only when a valid is in flight and hold otherwise. valid and last are delay-lined 2 deep.
- Frame counter (pair_cnt, width clog2(FRAME_PAIRS)), on each input beat:
  - Non-last beat, pair_cnt < FRAME_PAIRS-1: increment.
  - Non-last beat, pair_cnt = FRAME_PAIRS-1: set overflow sticky, hold the counter.
  - Last beat: len_err = sticky OR (pair_cnt ≠ FRAME_PAIRS-1); then clear the counter and sticky.
- Sat accumulator:
  - Adds popcount(out_sat) on each out_valid beat.
  - Saturates at all-ones.
  - On the out_last beat, the final sum including that beat is latched into frame_sat_cnt and the accumulator clears.
- frame_len_err is latched at the same cycle, from a len_err value delayed to align with out_last.
- in_last with in_valid=0 is ignored.
- Back-to-back frames (in_last followed immediately by a new frame) require no idle cycle.

Optional Feature:
- Macro: BUTTERFLY_REQUANT_CONVERGENT_EN.
- Defined: round half to even. When the discarded bits equal exactly 2^(SHIFT-1), the result is the even neighbour; all other cases behave as the default.
- Undefined: round half up, as above.
- Latency unchanged in both builds.

Decomposition:
- Package fft_requant_pkg holds:
  - width constants for the default configuration;
  - functions sat_max(w) and sat_min(w);
  - function popcount4.
- Sub-module requant_lane: one component through the 2-stage round/shift/saturate pipeline, with sat flag output. Instantiated 4× in butterfly_requant, which owns valid/last delay and frame logic.

Test Plan:
- Rounding: in_yp_r = 3·2^14 (1.5) → out 2. in_yp_r = -3·2^14 (-1.5) → out -1 (default) or -2 (CONVERGENT_EN). 5·2^14 (2.5) → 3 (default) or 2 (CONVERGENT_EN). Each with out_valid exactly 2 cycles after in_valid.
- Saturation: in_yq_r = 2^41 → out_yq_r = 67108863, out_sat = 4'b0100. in_yq_i = -2^42 → -67108864, out_sat = 4'b1000. in = 2^41 - 2^15 → 67108863 with sat = 0.
- Nominal frame: 512 consecutive beats, last on beat 511, 3 saturating components → one frame_done pulse aligned with out_last, frame_sat_cnt = 3, frame_len_err = 0.
- Length errors:
  - in_last on beat 100 → frame_len_err = 1.
  - 600 beats before in_last → frame_len_err = 1.
  - In both cases the next correct 512-beat frame reports 0.
- Gaps and back-to-back: random in_valid gaps → outputs match a reference model, with holds during gaps. Two frames with zero idle between → two frame_done pulses exactly 512 valid beats apart, counts independent.
- Reset mid-frame: assert rst_n low at beat 200 → all outputs 0 immediately. A following 512-beat frame → frame_len_err = 0, frame_sat_cnt correct.
